// File: rtl/mem_bridge_pkg.sv
// mem_bridge_pkg: types shared by the memory bridge and its lane aligner.
//   mem_size_t         - funct3-style access size encoding (B/H/W/BU/HU)
//   mem_bridge_state_t - bridge FSM states
package mem_bridge_pkg;

    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_size_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_REQ,
        S_WAIT_RSP,
        S_MISALIGN,
        S_RESP
    } mem_bridge_state_t;

    localparam int unsigned BYTES_PER_WORD = 4;

    // Word-aligned bus address for a byte address.
    function automatic logic [31:0] word_addr(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational byte-lane handling for a 32-bit bus.
//   size_i      access size (funct3 encoding)
//   addr_lo_i   byte offset within the word
//   wdata_i     LSB-aligned store data
//   rdata_raw_i raw bus read word
//   misalign_o  access is misaligned or size encoding is reserved
//   wstrb_o     byte enables for a store of this size/offset
//   wdata_o     store data replicated across all lanes
//   rdata_o     load data shifted down and sign/zero-extended
module mem_lane_align
    import mem_bridge_pkg::*;
(
    input  logic [2:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_raw_i,
    output logic        misalign_o,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [31:0] lane;

    always_comb begin
        lane       = rdata_raw_i >> {addr_lo_i, 3'b000};
        misalign_o = 1'b0;
        wstrb_o    = 4'b0000;
        wdata_o    = wdata_i;
        rdata_o    = 32'h0;
        case (size_i)
            MEM_B, MEM_BU: begin
                wstrb_o = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = (size_i == MEM_B) ? {{24{lane[7]}}, lane[7:0]}
                                            : {24'h0, lane[7:0]};
            end
            MEM_H, MEM_HU: begin
                misalign_o = addr_lo_i[0];
                wstrb_o    = 4'b0011 << addr_lo_i;
                wdata_o    = {2{wdata_i[15:0]}};
                rdata_o    = (size_i == MEM_H) ? {{16{lane[15]}}, lane[15:0]}
                                               : {16'h0, lane[15:0]};
            end
            MEM_W: begin
                misalign_o = (addr_lo_i != 2'b00);
                wstrb_o    = 4'b1111;
                rdata_o    = lane;
            end
            // Reserved encodings are rejected the same way as misalignment.
            default: misalign_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_bridge.sv
// mem_bridge: converts one-cycle mem_read/mem_write strobes from the multicycle
// control into a valid/ready bus transaction and returns a one-cycle mem_resp.
//   clk, rst                  clock, synchronous active-high reset
//   mem_read, mem_write       request strobes (write wins if both)
//   req_size, addr, wdata     operands, sampled the cycle after the strobe
//   mem_resp, rdata, err      completion pulse, load data, error with mem_resp
//   fault                     sticky error / dropped-strobe flag
//   bus_req_*, bus_we, bus_addr, bus_wstrb, bus_wdata   bus request side
//   bus_rsp_valid, bus_rdata  bus response side
module mem_bridge
    import mem_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned XLEN           = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic [2:0]      req_size,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    output logic            mem_resp,
    output logic [XLEN-1:0] rdata,
    output logic            err,
    output logic            fault,
    output logic            bus_req_valid,
    input  logic            bus_req_ready,
    output logic            bus_we,
    output logic [XLEN-1:0] bus_addr,
    output logic [3:0]      bus_wstrb,
    output logic [XLEN-1:0] bus_wdata,
    input  logic            bus_rsp_valid,
    input  logic [XLEN-1:0] bus_rdata
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    mem_bridge_state_t state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        size_q, size_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              fault_q, fault_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    // The aligner looks at live operands while capturing (to decide misalignment
    // and build store lanes) and at the captured ones afterwards (load extract).
    logic              in_capture;
    logic [2:0]        la_size;
    logic [1:0]        la_addr_lo;
    logic              la_misalign;
    logic [3:0]        la_wstrb;
    logic [31:0]       la_wdata;
    logic [31:0]       la_rdata;

    assign in_capture = (state_q == S_CAPTURE);
    assign la_size    = in_capture ? req_size   : size_q;
    assign la_addr_lo = in_capture ? addr[1:0]  : addr_q[1:0];

    mem_lane_align u_align (
        .size_i      (la_size),
        .addr_lo_i   (la_addr_lo),
        .wdata_i     (wdata),
        .rdata_raw_i (bus_rdata),
        .misalign_o  (la_misalign),
        .wstrb_o     (la_wstrb),
        .wdata_o     (la_wdata),
        .rdata_o     (la_rdata)
    );

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        fault_d = fault_q;
        cnt_d   = cnt_q;

        // Strobes arriving while busy are dropped; both at once is a control bug.
        if ((mem_read || mem_write) && (state_q != S_IDLE))
            fault_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (mem_read || mem_write) begin
                    we_d    = mem_write;
                    state_d = S_CAPTURE;
                    if (mem_read && mem_write)
                        fault_d = 1'b1;
                end
            end
            S_CAPTURE: begin
                size_d  = req_size;
                addr_d  = addr;
                wdata_d = la_wdata;
                wstrb_d = we_q ? la_wstrb : 4'b0000;
                err_d   = 1'b0;
                state_d = la_misalign ? S_MISALIGN : S_REQ;
            end
            S_REQ: begin
                if (bus_req_ready) begin
                    cnt_d   = '0;
                    state_d = S_WAIT_RSP;
                end
            end
            S_WAIT_RSP: begin
                if (bus_rsp_valid) begin
                    // Write acks carry no data; the last load value is kept.
                    if (!we_q)
                        rdata_d = la_rdata;
                    state_d = S_RESP;
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    rdata_d = 32'h0;
                    err_d   = 1'b1;
                    fault_d = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_MISALIGN: begin
                rdata_d = 32'h0;
                err_d   = 1'b1;
                fault_d = 1'b1;
                state_d = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            size_q  <= 3'b000;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            wstrb_q <= 4'b0000;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
            fault_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
        end
    end

    // Bus fields are only driven while the request is presented, so the bus
    // sees zeros whenever no request is pending.
    logic in_req;
    assign in_req        = (state_q == S_REQ);
    assign bus_req_valid = in_req;
    assign bus_we        = in_req & we_q;
    assign bus_addr      = in_req ? word_addr(addr_q) : 32'h0;
    assign bus_wstrb     = in_req ? wstrb_q : 4'b0000;
    assign bus_wdata     = in_req ? wdata_q : 32'h0;

    assign mem_resp = (state_q == S_RESP);
    assign err      = mem_resp & err_q;
    assign rdata    = rdata_q;
    assign fault    = fault_q;

endmodule
